// File: rtl/mul_seq_ctrl_if.sv
// Request/response channel between the EX stage and the sequential multiplier.
//   master : pipeline side; drives start_valid, op, rs1, rs2, result_ready
//   slave  : controller side; drives start_ready, result_valid, result
// op encoding: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
interface mul_seq_ctrl_if #(
  parameter int unsigned N = 32
);
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   op;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         result_valid;
  logic         result_ready;
  logic [N-1:0] result;

  modport master (
    output start_valid,
    output op,
    output rs1,
    output rs2,
    output result_ready,
    input  start_ready,
    input  result_valid,
    input  result
  );

  modport slave (
    input  start_valid,
    input  op,
    input  rs1,
    input  rs2,
    input  result_ready,
    output start_ready,
    output result_valid,
    output result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier controller for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at accept, multiplied unsigned over N
// cycles through one N-bit ripple-carry adder, then sign-corrected in a
// single FIX cycle. The selected half of the 2N-bit product is returned on a
// valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous abort of any in-flight or pending operation
//   busy  : high whenever the controller is not idle
//   bus   : request/response channel (slave side)
module mul_seq_ctrl #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic          busy,
  mul_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   ma_q, ma_d;
  logic           neg_q, neg_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic           result_valid_q, result_valid_d;

  // Operand conditioning at accept
  logic         sign_a, sign_b;
  logic [N-1:0] mag_a, mag_b;

  // Shared adder
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_c;

  logic [2*N-1:0] acc_fixed;

  // MUL only needs the low half, which is sign-independent, so it reuses
  // the MULH sign treatment.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    unique case (bus.op)
      2'b00:   begin sign_a = bus.rs1[N-1]; sign_b = bus.rs2[N-1]; end
      2'b01:   begin sign_a = bus.rs1[N-1]; sign_b = bus.rs2[N-1]; end
      2'b10:   begin sign_a = bus.rs1[N-1]; sign_b = 1'b0;         end
      default: begin sign_a = 1'b0;         sign_b = 1'b0;         end
    endcase
    // Negating -2^(N-1) yields 2^(N-1) read as unsigned, which is exact.
    mag_a = sign_a ? (~bus.rs1 + {{(N-1){1'b0}}, 1'b1}) : bus.rs1;
    mag_b = sign_b ? (~bus.rs2 + {{(N-1){1'b0}}, 1'b1}) : bus.rs2;
  end

  // N-bit ripple-carry adder, carry-in 0
  always_comb begin
    logic carry;
    add_a   = acc_q[2*N-1:N];
    add_b   = acc_q[0] ? ma_q : '0;
    add_sum = '0;
    carry   = 1'b0;
    for (int i = 0; i < N; i++) begin
      add_sum[i] = add_a[i] ^ add_b[i] ^ carry;
      carry      = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
    end
    add_c = carry;
  end

  // Two's complement over the full product; a zero product stays zero.
  assign acc_fixed = neg_q ? (~acc_q + {{(2*N-1){1'b0}}, 1'b1}) : acc_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    acc_d          = acc_q;
    ma_d           = ma_q;
    neg_d          = neg_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_valid) begin
          ma_d    = mag_a;
          acc_d   = {{N{1'b0}}, mag_b};
          neg_d   = sign_a ^ sign_b;
          op_d    = bus.op;
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d   = {add_c, add_sum, acc_q[N-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CntW'(N - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        acc_d          = acc_fixed;
        result_d       = (op_q == 2'b00) ? acc_fixed[N-1:0] : acc_fixed[2*N-1:N];
        result_valid_d = 1'b1;
        state_d        = StDone;
      end
      StDone: begin
        if (bus.result_ready) begin
          result_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides any handshake, including an accept in IDLE.
    if (flush) begin
      state_d        = StIdle;
      result_valid_d = 1'b0;
      count_d        = '0;
      acc_d          = acc_q;
      ma_d           = ma_q;
      neg_d          = neg_q;
      op_d           = op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      acc_q          <= '0;
      ma_q           <= '0;
      neg_q          <= 1'b0;
      op_q           <= 2'b00;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      ma_q           <= ma_d;
      neg_q          <= neg_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign bus.start_ready  = (state_q == StIdle);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;

endmodule
